// File: rtl/bcd_updown_counter_pkg.sv
// Shared definitions for the multi-digit BCD up/down counter.
//   bcd_digit_t : one packed BCD digit (4 bits)
//   BCD_MAX     : largest legal digit value (9)
//   BCD_MIN     : smallest legal digit value (0)
//   DIGITS_MAX  : largest supported digit count
package bcd_updown_counter_pkg;

   localparam int DIGITS_MAX = 8;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit register of the up/down counter.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low; clears the digit to 0
//   load       : parallel load strobe, has priority over step
//   load_digit : value to load, already restricted to 0..9 by the caller
//   step       : advance this digit by one in the direction given by up
//   up         : 1 = increment, 0 = decrement
//   digit      : current digit value
//   is_max     : digit is 9 (carry condition when counting up)
//   is_min     : digit is 0 (borrow condition when counting down)
import bcd_updown_counter_pkg::*;

module bcd_digit (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  bcd_digit_t load_digit,
   input  logic       step,
   input  logic       up,
   output bcd_digit_t digit,
   output logic       is_max,
   output logic       is_min
);

   assign is_max = (digit == BCD_MAX);
   assign is_min = (digit == BCD_MIN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit <= BCD_MIN;
      end else if (load) begin
         digit <= load_digit;
      end else if (step) begin
         // Wrap within the digit; the carry/borrow into the next digit is
         // formed by the parent from is_max / is_min.
         if (up)
            digit <= is_max ? BCD_MIN : digit + 4'd1;
         else
            digit <= is_min ? BCD_MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Synchronous multi-digit packed-BCD up/down counter with parallel load.
// All digits update on the same clock edge; carries and borrows are formed
// combinationally from lower-digit is_max / is_min flags.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active low
//   en       : count enable, one step per enabled cycle
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous parallel load, priority over en
//   load_val : packed BCD load value, digit i at [4i+3:4i]
//   count    : current packed BCD count
//   tc       : combinational terminal count (all 9s going up / all 0s going down)
//   wrap     : registered pulse, the cycle after a wrap-around step
//   load_err : registered pulse, the cycle after a load holding a digit > 9
import bcd_updown_counter_pkg::*;

module bcd_updown_counter #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tc,
   output logic                  wrap,
   output logic                  load_err
);

   // Illegal load codes (10..15) are replaced by 0.
   function automatic bcd_digit_t sanitize_digit(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MIN : d;
   endfunction

   function automatic logic digit_invalid(input logic [3:0] d);
      return (d > BCD_MAX);
   endfunction

   logic [DIGITS-1:0] is_max;
   logic [DIGITS-1:0] is_min;
   logic [DIGITS-1:0] step;
   logic [DIGITS-1:0] bad;

   // max_chain[i] / min_chain[i]: all digits below i are 9 / 0.
   // Entry DIGITS covers the whole counter.
   logic [DIGITS:0] max_chain;
   logic [DIGITS:0] min_chain;

   assign max_chain[0] = 1'b1;
   assign min_chain[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_t ld_digit;
      bcd_digit_t cur_digit;

      assign ld_digit         = sanitize_digit(load_val[4*i +: 4]);
      assign bad[i]           = digit_invalid(load_val[4*i +: 4]);
      assign max_chain[i+1]   = max_chain[i] & is_max[i];
      assign min_chain[i+1]   = min_chain[i] & is_min[i];
      assign step[i]          = en & (up ? max_chain[i] : min_chain[i]);
      assign count[4*i +: 4]  = cur_digit;

      bcd_digit u_digit (
         .clk        (clk),
         .rst        (rst),
         .load       (load),
         .load_digit (ld_digit),
         .step       (step[i]),
         .up         (up),
         .digit      (cur_digit),
         .is_max     (is_max[i]),
         .is_min     (is_min[i])
      );
   end

   assign tc = up ? max_chain[DIGITS] : min_chain[DIGITS];

   // ---- registered status flags, valid the cycle after their cause ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         // A step taken while at terminal count is exactly a wrap-around.
         wrap     <= !load && en && tc;
         load_err <= load && (|bad);
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // DIGITS = 4 instance
   logic        en_a = 1'b0, up_a = 1'b1, load_a = 1'b0;
   logic [15:0] lv_a = '0;
   logic [15:0] count_a;
   logic        tc_a, wrap_a, lerr_a;

   // DIGITS = 1 instance
   logic        en_b = 1'b0, up_b = 1'b1, load_b = 1'b0;
   logic [3:0]  lv_b = '0;
   logic [3:0]  count_b;
   logic        tc_b, wrap_b, lerr_b;

   // DIGITS = 8 instance
   logic        en_c = 1'b0, up_c = 1'b1, load_c = 1'b0;
   logic [31:0] lv_c = '0;
   logic [31:0] count_c;
   logic        tc_c, wrap_c, lerr_c;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_up [12] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                16'h0005, 16'h0006, 16'h0007, 16'h0008,
                                16'h0009, 16'h0010, 16'h0011, 16'h0012};

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(4)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(load_a),
      .load_val(lv_a), .count(count_a), .tc(tc_a), .wrap(wrap_a), .load_err(lerr_a)
   );

   bcd_updown_counter #(.DIGITS(1)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(load_b),
      .load_val(lv_b), .count(count_b), .tc(tc_b), .wrap(wrap_b), .load_err(lerr_b)
   );

   bcd_updown_counter #(.DIGITS(8)) dut_c (
      .clk(clk), .rst(rst), .en(en_c), .up(up_c), .load(load_c),
      .load_val(lv_c), .count(count_c), .tc(tc_c), .wrap(wrap_c), .load_err(lerr_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are
   // sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_count", 32'(count_a), 32'h0);
      chk("rst_wrap", 32'(wrap_a), 32'h0);
      chk("rst_lerr", 32'(lerr_a), 32'h0);
      chk("rst_tc_up", 32'(tc_a), 32'h0);
      up_a = 1'b0;
      #1;
      chk("rst_tc_down", 32'(tc_a), 32'h1);
      up_a = 1'b1;
      tick();
      chk("rst_hold_count", 32'(count_a), 32'h0);
      rst = 1'b1;

      // Up count, 12 steps
      chk("up_start", 32'(count_a), 32'h0);
      en_a = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("up_count", 32'(count_a), 32'(exp_up[k]));
         chk("up_nowrap", 32'(wrap_a), 32'h0);
      end
      en_a = 1'b0;

      // Up wrap from 9999
      load_a = 1'b1; lv_a = 16'h9999;
      tick();
      load_a = 1'b0;
      chk("ld9999_count", 32'(count_a), 32'h9999);
      chk("ld9999_tc", 32'(tc_a), 32'h1);
      chk("ld9999_lerr", 32'(lerr_a), 32'h0);
      en_a = 1'b1;
      tick();
      en_a = 1'b0;
      chk("upwrap_count", 32'(count_a), 32'h0000);
      chk("upwrap_wrap", 32'(wrap_a), 32'h1);
      chk("upwrap_tc", 32'(tc_a), 32'h0);
      tick();
      chk("upwrap_wrap_end", 32'(wrap_a), 32'h0);
      chk("upwrap_hold", 32'(count_a), 32'h0000);

      // Down with borrow from 0100
      load_a = 1'b1; lv_a = 16'h0100;
      tick();
      load_a = 1'b0;
      up_a = 1'b0; en_a = 1'b1;
      tick();
      chk("borrow1", 32'(count_a), 32'h0099);
      tick();
      chk("borrow2", 32'(count_a), 32'h0098);
      chk("borrow_tc", 32'(tc_a), 32'h0);
      en_a = 1'b0;

      // Down wrap from 0000
      load_a = 1'b1; lv_a = 16'h0000;
      tick();
      load_a = 1'b0;
      chk("ld0_tc_down", 32'(tc_a), 32'h1);
      en_a = 1'b1;
      tick();
      en_a = 1'b0;
      chk("dnwrap_count", 32'(count_a), 32'h9999);
      chk("dnwrap_wrap", 32'(wrap_a), 32'h1);
      tick();
      chk("dnwrap_wrap_end", 32'(wrap_a), 32'h0);

      // Load priority with invalid digit
      load_a = 1'b1; en_a = 1'b1; up_a = 1'b1; lv_a = 16'h12F4;
      tick();
      load_a = 1'b0; en_a = 1'b0;
      chk("ldbad_count", 32'(count_a), 32'h1204);
      chk("ldbad_lerr", 32'(lerr_a), 32'h1);
      chk("ldbad_wrap", 32'(wrap_a), 32'h0);
      tick();
      chk("ldbad_lerr_end", 32'(lerr_a), 32'h0);
      chk("ldbad_hold", 32'(count_a), 32'h1204);

      // Mid-operation asynchronous reset
      en_a = 1'b1; up_a = 1'b1;
      tick();
      chk("pre_rst1", 32'(count_a), 32'h1205);
      tick();
      chk("pre_rst2", 32'(count_a), 32'h1206);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_count", 32'(count_a), 32'h0);
      chk("async_rst_wrap", 32'(wrap_a), 32'h0);
      tick();
      chk("in_rst_count", 32'(count_a), 32'h0);
      rst = 1'b1;
      tick();
      chk("post_rst_count", 32'(count_a), 32'h0001);
      up_a = 1'b0;
      tick();
      chk("dir_change", 32'(count_a), 32'h0000);
      chk("dir_change_tc", 32'(tc_a), 32'h1);
      en_a = 1'b0;

      // DIGITS = 1
      load_b = 1'b1; lv_b = 4'h9;
      tick();
      load_b = 1'b0;
      chk("d1_tc_up", 32'(tc_b), 32'h1);
      en_b = 1'b1;
      tick();
      chk("d1_upwrap", 32'(count_b), 32'h0);
      chk("d1_upwrap_w", 32'(wrap_b), 32'h1);
      up_b = 1'b0;
      tick();
      en_b = 1'b0;
      chk("d1_dnwrap", 32'(count_b), 32'h9);
      chk("d1_dnwrap_w", 32'(wrap_b), 32'h1);
      tick();
      chk("d1_wrap_end", 32'(wrap_b), 32'h0);

      // DIGITS = 8
      load_c = 1'b1; lv_c = 32'h99999999;
      tick();
      load_c = 1'b0;
      chk("d8_tc_up", 32'(tc_c), 32'h1);
      en_c = 1'b1;
      tick();
      chk("d8_upwrap", count_c, 32'h00000000);
      chk("d8_upwrap_w", 32'(wrap_c), 32'h1);
      up_c = 1'b0;
      tick();
      chk("d8_dnwrap", count_c, 32'h99999999);
      chk("d8_dnwrap_w", 32'(wrap_c), 32'h1);
      tick();
      en_c = 1'b0;
      chk("d8_dn_step", count_c, 32'h99999998);
      chk("d8_wrap_end", 32'(wrap_c), 32'h0);
      load_c = 1'b1; lv_c = 32'h10000000; en_c = 1'b1;
      tick();
      load_c = 1'b0;
      tick();
      en_c = 1'b0;
      chk("d8_long_borrow", count_c, 32'h09999999);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
